// File: rtl/video_geom_monitor_if.sv
// rtl/video_geom_monitor_if.sv - sample/status bundle for video_geom_monitor; h_min/h_max exist only with VGM_MINMAX_EN
interface video_geom_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH-1:0]       vsync;
  logic                    err_clr;
  logic [NUM_CH*CNT_W-1:0] h_len;
  logic [NUM_CH*CNT_W-1:0] v_len;
  logic [NUM_CH*CNT_W-1:0] frame_cnt;
  logic [NUM_CH-1:0]       h_err;
  logic [NUM_CH-1:0]       v_err;
  logic [NUM_CH-1:0]       h_err_sticky;
  logic [NUM_CH-1:0]       v_err_sticky;
`ifdef VGM_MINMAX_EN
  logic [NUM_CH*CNT_W-1:0] h_min;
  logic [NUM_CH*CNT_W-1:0] h_max;
`endif

  // Pipeline side: drives the sampled video strobes, observes the results.
  modport master (
`ifdef VGM_MINMAX_EN
    input  h_min, h_max,
`endif
    output valid, vsync, err_clr,
    input  h_len, v_len, frame_cnt, h_err, v_err, h_err_sticky, v_err_sticky
  );

  // Monitor side.
  modport slave (
`ifdef VGM_MINMAX_EN
    output h_min, h_max,
`endif
    input  valid, vsync, err_clr,
    output h_len, v_len, frame_cnt, h_err, v_err, h_err_sticky, v_err_sticky
  );
endinterface

// File: rtl/video_geom_monitor.sv
// rtl/video_geom_monitor.sv - per-channel line length / lines-per-frame monitor; optional min/max via VGM_MINMAX_EN
module video_geom_monitor #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int EXP_H  = 1280,
  parameter int EXP_V  = 720
) (
  input  logic                 I_Clk,
  input  logic                 Rst,
  video_geom_monitor_if.slave  mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0]      EXP_H_W = 32'(EXP_H);
  localparam logic [31:0]      EXP_V_W = 32'(EXP_V);

  logic [NUM_CH-1:0] valid_d, vsync_d, armed;
  logic [NUM_CH-1:0] h_err_q, v_err_q, h_stk_q, v_stk_q;
  logic [CNT_W-1:0]  hcnt_q  [NUM_CH];
  logic [CNT_W-1:0]  vcnt_q  [NUM_CH];
  logic [CNT_W-1:0]  h_len_q [NUM_CH];
  logic [CNT_W-1:0]  v_len_q [NUM_CH];
  logic [CNT_W-1:0]  frame_q [NUM_CH];

  logic [NUM_CH-1:0] fall, vrise, h_bad, v_bad;
  logic [CNT_W-1:0]  hcnt_inc [NUM_CH];
  logic [CNT_W-1:0]  v_close  [NUM_CH];

  // Edge detection plus the values each channel would close a line/frame with.
  // A line ending on the vsync edge is counted into the frame being closed.
  always_comb begin
    fall  = ~mon.valid & valid_d;
    vrise = mon.vsync & ~vsync_d;
    h_bad = '0;
    v_bad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hcnt_inc[c] = (hcnt_q[c] == CNT_MAX) ? CNT_MAX : hcnt_q[c] + CNT_ONE;
      v_close[c]  = (fall[c] && (vcnt_q[c] != CNT_MAX)) ? vcnt_q[c] + CNT_ONE : vcnt_q[c];
      h_bad[c]    = (hcnt_q[c] == CNT_MAX) || (32'(hcnt_q[c]) != EXP_H_W);
      v_bad[c]    = (32'(v_close[c]) != EXP_V_W);
    end
  end

  // Counters, latched geometry, error pulses and sticky flags for every channel.
  always_ff @(posedge I_Clk or negedge Rst) begin
    if (!Rst) begin
      valid_d <= '0;
      vsync_d <= '0;
      armed   <= '0;
      h_err_q <= '0;
      v_err_q <= '0;
      h_stk_q <= '0;
      v_stk_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hcnt_q[c]  <= '0;
        vcnt_q[c]  <= '0;
        h_len_q[c] <= '0;
        v_len_q[c] <= '0;
        frame_q[c] <= '0;
      end
    end else begin
      valid_d <= mon.valid;
      vsync_d <= mon.vsync;
      h_err_q <= '0;
      v_err_q <= '0;
      // Sticky flags follow the registered pulse so a clear coinciding with a
      // visible pulse cannot lose it.
      h_stk_q <= h_err_q | (h_stk_q & ~{NUM_CH{mon.err_clr}});
      v_stk_q <= v_err_q | (v_stk_q & ~{NUM_CH{mon.err_clr}});
      for (int c = 0; c < NUM_CH; c++) begin
        if (fall[c]) begin
          h_len_q[c] <= hcnt_q[c];
          hcnt_q[c]  <= '0;
          h_err_q[c] <= h_bad[c];
        end else if (mon.valid[c]) begin
          hcnt_q[c]  <= hcnt_inc[c];
        end

        if (vrise[c]) begin
          v_len_q[c] <= v_close[c];
          vcnt_q[c]  <= '0;
          armed[c]   <= 1'b1;
          // The first frame after reset is partial: no check, not counted.
          if (armed[c]) begin
            v_err_q[c] <= v_bad[c];
            frame_q[c] <= frame_q[c] + CNT_ONE;
          end
        end else if (fall[c]) begin
          vcnt_q[c]  <= v_close[c];
        end
      end
    end
  end

`ifdef VGM_MINMAX_EN
  logic [CNT_W-1:0] run_min_q [NUM_CH];
  logic [CNT_W-1:0] run_max_q [NUM_CH];
  logic [CNT_W-1:0] h_min_q   [NUM_CH];
  logic [CNT_W-1:0] h_max_q   [NUM_CH];
  logic [CNT_W-1:0] min_next  [NUM_CH];
  logic [CNT_W-1:0] max_next  [NUM_CH];

  // Running extremes including a line that completes on this edge.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      min_next[c] = (fall[c] && (hcnt_q[c] < run_min_q[c])) ? hcnt_q[c] : run_min_q[c];
      max_next[c] = (fall[c] && (hcnt_q[c] > run_max_q[c])) ? hcnt_q[c] : run_max_q[c];
    end
  end

  // Latch the frame extremes on vsync and restart tracking for the new frame.
  always_ff @(posedge I_Clk or negedge Rst) begin
    if (!Rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        run_min_q[c] <= CNT_MAX;
        run_max_q[c] <= '0;
        h_min_q[c]   <= '0;
        h_max_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (vrise[c]) begin
          h_min_q[c]   <= min_next[c];
          h_max_q[c]   <= max_next[c];
          run_min_q[c] <= CNT_MAX;
          run_max_q[c] <= '0;
        end else if (fall[c]) begin
          run_min_q[c] <= min_next[c];
          run_max_q[c] <= max_next[c];
        end
      end
    end
  end

  // Pack the per-channel extremes onto the shared buses.
  always_comb begin
    mon.h_min = '0;
    mon.h_max = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mon.h_min[c*CNT_W +: CNT_W] = h_min_q[c];
      mon.h_max[c*CNT_W +: CNT_W] = h_max_q[c];
    end
  end
`endif

  // Pack per-channel results onto the shared output buses.
  always_comb begin
    mon.h_len        = '0;
    mon.v_len        = '0;
    mon.frame_cnt    = '0;
    mon.h_err        = h_err_q;
    mon.v_err        = v_err_q;
    mon.h_err_sticky = h_stk_q;
    mon.v_err_sticky = v_stk_q;
    for (int c = 0; c < NUM_CH; c++) begin
      mon.h_len[c*CNT_W +: CNT_W]     = h_len_q[c];
      mon.v_len[c*CNT_W +: CNT_W]     = v_len_q[c];
      mon.frame_cnt[c*CNT_W +: CNT_W] = frame_q[c];
    end
  end

endmodule
